// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
// Arrow defaults are E0-extended make codes packed as {ext, code}.
package ps2_pkg;

  typedef struct packed {
    logic       press;
    logic       ext;
    logic [7:0] code;
  } key_evt_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam logic [8:0] KEY_RIGHT = 9'h174;
  localparam logic [8:0] KEY_LEFT  = 9'h16B;
  localparam logic [8:0] KEY_DOWN  = 9'h172;
  localparam logic [8:0] KEY_UP    = 9'h175;

  // The Pause sequence is E1 followed by seven more bytes that carry no key event.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the pins, samples data on psClk falling
// edges and emits one byte strobe per valid frame or an error strobe.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps_clk,
  input  logic       ps_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int               TW          = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]    TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [TW-1:0]          timer_q, timer_d;

  rx_state_t  state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       parity_q;
  logic [7:0] rx_byte_q;
  logic       rx_valid_q;
  logic       rx_err_q;

  logic fall;
  logic bit_in;
  logic timeout;

  assign fall    = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign bit_in  = data_sync_q[SYNC_STAGES-1];
  assign timeout = (timer_q == TIMEOUT_MAX) && !fall && (state_q != RX_IDLE);

  // The timer saturates while the bus is idle so a long pause never wraps into a false timeout.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps_data};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    if (fall) begin
      timer_d = '0;
    end else if (timer_q == TIMEOUT_MAX) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      timer_q     <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      timer_q     <= timer_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (timeout) begin
        state_q  <= RX_IDLE;
        rx_err_q <= 1'b1;
      end else if (fall) begin
        case (state_q)
          RX_IDLE: begin
            if (!bit_in) begin
              state_q   <= RX_DATA;
              bit_cnt_q <= '0;
            end
          end
          RX_DATA: begin
            shift_q   <= {bit_in, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_q <= bit_in;
            state_q  <= RX_STOP;
          end
          RX_STOP: begin
            state_q <= RX_IDLE;
            if (bit_in && (^{shift_q, parity_q})) begin
              rx_byte_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              rx_err_q <= 1'b1;
            end
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: decodes make/break/E0 scancodes, tracks held state
// of watched keys and queues every key event in a first-word-fall-through FIFO.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT},
  parameter int                    SYNC_STAGES    = 2,
  parameter int                    TIMEOUT_CYCLES = 50000,
  parameter int                    FIFO_DEPTH     = 8
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                psClk,
  input  logic                psData,
  output logic [7:0]          keyCode,
  output logic                keyExt,
  output logic                press,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_edge,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [9:0]          evt_data,
  output logic                evt_overflow,
  output logic                frame_err
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE = 1;

  // Reset asserts immediately but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst = rst_sync_q[1];

  logic [7:0] rx_byte;
  logic       rx_valid;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (Clk),
    .rst     (rst),
    .ps_clk  (psClk),
    .ps_data (psData),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (frame_err)
  );

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [2:0] skip_q, skip_d;
  logic       evt_fire;
  key_evt_t   evt;

  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    skip_d     = skip_q;
    evt_fire   = 1'b0;
    evt.press  = ~brk_q;
    evt.ext    = ext_q;
    evt.code   = rx_byte;
    if (rx_valid) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (rx_byte == PS2_PAUSE) skip_d = PAUSE_TAIL;
        else if (!is_discard(rx_byte)) evt_fire = 1'b1;
      end
    end
  end

  logic [7:0]          key_code_q, key_code_d;
  logic                key_ext_q, key_ext_d;
  logic                press_q, press_d;
  logic [NUM_KEYS-1:0] key_down_q, key_down_d;
  logic [NUM_KEYS-1:0] key_edge_q, key_edge_d;

  // Repeats of an already-held key leave key_down unchanged, so no edge is raised.
  always_comb begin
    key_code_d = key_code_q;
    key_ext_d  = key_ext_q;
    press_d    = press_q;
    key_down_d = key_down_q;
    if (evt_fire) begin
      key_code_d = evt.code;
      key_ext_d  = evt.ext;
      press_d    = evt.press;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if ({evt.ext, evt.code} == KEY_CODES[i*9 +: 9]) key_down_d[i] = evt.press;
      end
    end
    key_edge_d = key_down_d ^ key_down_q;
  end

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  key_evt_t    mem_q [FIFO_DEPTH];
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        push_ok;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && evt_ready;
  // A pop frees the head slot in the same cycle, so a push into a full FIFO still fits.
  assign push_ok    = evt_fire && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    overflow_d = overflow_q | (evt_fire && fifo_full && !pop);
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= '0;
      key_code_q <= '0;
      key_ext_q  <= 1'b0;
      press_q    <= 1'b0;
      key_down_q <= '0;
      key_edge_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      skip_q     <= skip_d;
      key_code_q <= key_code_d;
      key_ext_q  <= key_ext_d;
      press_q    <= press_d;
      key_down_q <= key_down_d;
      key_edge_q <= key_edge_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= evt;
  end

  assign keyCode      = key_code_q;
  assign keyExt       = key_ext_q;
  assign press        = press_q;
  assign key_down     = key_down_q;
  assign key_edge     = key_edge_q;
  assign evt_valid    = !fifo_empty;
  assign evt_data     = fifo_empty ? 10'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign evt_overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: a byte-level decoder model queues the
// expected events, a negedge monitor pops and compares them as the FIFO drains.
module tb_ps2_key_tracker;

  localparam int HALF    = 10;
  localparam int TIMEOUT = 50000;

  logic       Clk = 1'b0;
  logic       reset;
  logic       psClk;
  logic       psData;
  logic       evt_ready;
  logic [7:0] keyCode;
  logic       keyExt;
  logic       press;
  logic [3:0] key_down;
  logic [3:0] key_edge;
  logic       evt_valid;
  logic [9:0] evt_data;
  logic       evt_overflow;
  logic       frame_err;

  int compare_cnt  = 0;
  int mismatch_cnt = 0;
  int err_cnt      = 0;
  int edge_cnt3    = 0;

  logic [9:0] exp_q [$];
  logic [3:0] exp_kd   = 4'b0;
  logic [3:0] kd_prev  = 4'b0;
  logic       m_ext    = 1'b0;
  logic       m_brk    = 1'b0;
  int         m_skip   = 0;
  logic [8:0] watch [4] = '{9'h174, 9'h16B, 9'h172, 9'h175};

  ps2_key_tracker dut (
    .Clk         (Clk),
    .reset       (reset),
    .psClk       (psClk),
    .psData      (psData),
    .keyCode     (keyCode),
    .keyExt      (keyExt),
    .press       (press),
    .key_down    (key_down),
    .key_edge    (key_edge),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_data    (evt_data),
    .evt_overflow(evt_overflow),
    .frame_err   (frame_err)
  );

  always #10 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_cnt++;
    if (obs !== exp) begin
      mismatch_cnt++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Reference decoder for one received byte.
  task automatic modelByte(input logic [7:0] b);
    logic [9:0] ev;
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (b == 8'hE1) begin
        m_skip = 7;
      end else if (!(b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) begin
        ev = {~m_brk, m_ext, b};
        for (int k = 0; k < 4; k++) if (ev[8:0] == watch[k]) exp_kd[k] = ev[9];
        if (evt_ready || exp_q.size() < 8) exp_q.push_back(ev);
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                               input int nbits, input bit chk_lat);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      psData = fr[i];
      tick(HALF);
      psClk = 1'b0;
      if (chk_lat && i == 10) begin
        tick(3);
        checkOutput("lat_t1_valid", evt_valid, 1'b0);
        tick(1);
        checkOutput("lat_t2_valid", evt_valid, 1'b1);
        tick(HALF - 4);
      end else begin
        tick(HALF);
      end
      psClk = 1'b1;
    end
    psData = 1'b1;
    tick(HALF);
  endtask

  task automatic sendKey(input logic [7:0] b);
    modelByte(b);
    applyStimulus(b, 1'b0, 1'b0, 11, 1'b0);
  endtask

  always @(negedge Clk) begin
    if (!reset) begin
      err_cnt   += int'(frame_err);
      edge_cnt3 += int'(key_edge[3]);
      if (key_edge != 4'b0 || key_down != kd_prev)
        checkOutput("key_edge", key_edge, key_down ^ kd_prev);
      if (evt_valid && evt_ready) begin
        checkOutput("evt_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) checkOutput("evt_data", evt_data, exp_q.pop_front());
      end
    end
    kd_prev = key_down;
  end

  initial begin
    #20000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int e0;
    reset = 1'b1; psClk = 1'b1; psData = 1'b1; evt_ready = 1'b0;
    tick(5);
    checkOutput("rst_keyCode", keyCode, 8'h00);
    checkOutput("rst_press", press, 1'b0);
    checkOutput("rst_key_down", key_down, 4'h0);
    checkOutput("rst_evt_valid", evt_valid, 1'b0);
    checkOutput("rst_evt_data", evt_data, 10'h000);
    checkOutput("rst_overflow", evt_overflow, 1'b0);
    reset = 1'b0;
    tick(10);

    $display("[TB] single make 1C with latency check");
    modelByte(8'h1C);
    applyStimulus(8'h1C, 1'b0, 1'b0, 11, 1'b1);
    checkOutput("a_keyCode", keyCode, 8'h1C);
    checkOutput("a_press", press, 1'b1);
    checkOutput("a_keyExt", keyExt, 1'b0);
    checkOutput("a_key_down", key_down, 4'h0);
    checkOutput("a_evt_valid", evt_valid, 1'b1);
    evt_ready = 1'b1;
    tick(5);
    checkOutput("a_drained", exp_q.size(), 0);

    $display("[TB] up arrow make then break");
    e0 = edge_cnt3;
    sendKey(8'hE0); sendKey(8'h75);
    checkOutput("up_make_down", key_down, exp_kd);
    checkOutput("up_make_edges", edge_cnt3 - e0, 1);
    checkOutput("up_make_ext", keyExt, 1'b1);
    sendKey(8'hE0); sendKey(8'hF0); sendKey(8'h75);
    checkOutput("up_brk_down", key_down, exp_kd);
    checkOutput("up_brk_edges", edge_cnt3 - e0, 2);
    checkOutput("up_brk_press", press, 1'b0);

    $display("[TB] typematic repeat");
    e0 = edge_cnt3;
    repeat (3) begin sendKey(8'hE0); sendKey(8'h75); end
    checkOutput("rep_down", key_down, 4'b1000);
    checkOutput("rep_edges", edge_cnt3 - e0, 1);
    checkOutput("rep_drained", exp_q.size(), 0);
    sendKey(8'hE0); sendKey(8'hF0); sendKey(8'h75);

    $display("[TB] parity and stop errors");
    e0 = err_cnt;
    applyStimulus(8'h1C, 1'b1, 1'b0, 11, 1'b0);
    checkOutput("par_err", err_cnt - e0, 1);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    checkOutput("stop_err", err_cnt - e0, 2);
    checkOutput("err_keyCode", keyCode, 8'h75);

    $display("[TB] pause sequence and discard bytes");
    foreach (watch[k]) begin end
    sendKey(8'hE1); sendKey(8'h14); sendKey(8'h77); sendKey(8'hE1);
    sendKey(8'hF0); sendKey(8'h14); sendKey(8'hF0); sendKey(8'h77);
    sendKey(8'hAA); sendKey(8'h2D);
    checkOutput("pause_keyCode", keyCode, 8'h2D);
    checkOutput("pause_press", press, 1'b1);

    $display("[TB] timeout after partial frame");
    e0 = err_cnt;
    applyStimulus(8'h1C, 1'b0, 1'b0, 5, 1'b0);
    tick(TIMEOUT - 1000);
    checkOutput("to_early", err_cnt - e0, 0);
    tick(1100);
    checkOutput("to_err", err_cnt - e0, 1);
    sendKey(8'h1C);
    checkOutput("to_recover", keyCode, 8'h1C);

    $display("[TB] FIFO overflow");
    evt_ready = 1'b0;
    tick(2);
    for (int i = 0; i < 9; i++) sendKey(8'h15 + 8'(i));
    checkOutput("ovf_valid", evt_valid, 1'b1);
    checkOutput("ovf_flag", evt_overflow, 1'b1);
    evt_ready = 1'b1;
    tick(20);
    checkOutput("ovf_drained", exp_q.size(), 0);
    checkOutput("ovf_empty", evt_valid, 1'b0);
    checkOutput("ovf_sticky", evt_overflow, 1'b1);

    $display("[TB] reset mid-frame");
    evt_ready = 1'b0;
    sendKey(8'hE0); sendKey(8'h75);
    applyStimulus(8'h1C, 1'b0, 1'b0, 5, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("mr_keyCode", keyCode, 8'h00);
    checkOutput("mr_keyExt", keyExt, 1'b0);
    checkOutput("mr_press", press, 1'b0);
    checkOutput("mr_key_down", key_down, 4'h0);
    checkOutput("mr_key_edge", key_edge, 4'h0);
    checkOutput("mr_evt_valid", evt_valid, 1'b0);
    checkOutput("mr_evt_data", evt_data, 10'h000);
    checkOutput("mr_overflow", evt_overflow, 1'b0);
    checkOutput("mr_frame_err", frame_err, 1'b0);
    exp_q.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0; exp_kd = 4'b0;
    tick(3);
    reset = 1'b0;
    evt_ready = 1'b1;
    tick(10);
    sendKey(8'h1C);
    checkOutput("mr_recover", keyCode, 8'h1C);
    checkOutput("mr_recover_down", key_down, exp_kd);
    tick(10);
    checkOutput("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule
